ctrl_pipeline: RTL and testbench
================================

# ctrl_pipeline

Carries the decoded control bundle from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the five-stage RISC-V core. It consumes the decoder's control signals, `flush` and the register specifiers. It detects load-use hazards, inserts bubbles, and produces the PC/IF-ID write enables and the IF/ID flush. Each downstream stage reads its control signals only from this block.

## Interface
- `ZERO_REG`, default 5'd0: register index treated as hardwired zero; never causes a hazard.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hold` in 1: global freeze from the memory system; no stage register updates while high.
- `id_alu_op` in 2: ALUOp from the decoder (00 add, 01 sub, 10 R-type).
- `id_alu_src`, `id_branch`, `id_mem_read`, `id_mem_2_reg`, `id_mem_write`, `id_reg_write`, `id_jump` in 1 each: decoder control bits for the instruction in ID.
- `id_flush` in 1: decoder's taken-branch/jump indication.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register specifiers of the instruction in ID.
- `ex_alu_op` out 2, `ex_alu_src` out 1: EX-stage controls.
- `ex_rd` out 5: destination register of the instruction in EX.
- `mem_mem_read`, `mem_mem_write` out 1: MEM-stage controls.
- `mem_rd` out 5: destination register of the instruction in MEM.
- `mem_reg_write` out 1: MEM-stage write-enable, used for forwarding.
- `wb_reg_write`, `wb_mem_2_reg` out 1: WB-stage controls.
- `wb_rd` out 5: destination register of the instruction in WB.
- `pc_write` out 1: PC update enable.
- `if_id_write` out 1: IF/ID register update enable.
- `if_id_flush` out 1: squash the instruction currently in IF/ID.

## Operation
- Stage registers
  - ID/EX holds the full bundle plus rd.
  - EX/MEM drops alu_op/alu_src.
  - MEM/WB keeps reg_write, mem_2_reg and rd.
- Load-use stall
  - Condition: `stall = ex_mem_read_q & (ex_rd != ZERO_REG) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
  - On stall, a bubble is written into ID/EX: all control bits 0, rd = 0.
  - `pc_write = if_id_write = 0` for that cycle.
  - EX/MEM and MEM/WB advance normally.
- A stall lasts exactly one cycle per load. The next cycle the load sits in MEM and the stall condition is false.
- Flush
  - `if_id_flush = id_flush & ~stall & ~hold`.
  - The branch/jump in ID still advances into ID/EX with its own bits (branch/jump are not carried further).
- Simultaneous stall and flush: stall wins. `id_flush` is ignored because regEqual depends on the in-flight load. The decoder re-asserts `id_flush` on the retried cycle.
- Hold: all stage registers retain their value; `pc_write = if_id_write = if_id_flush = 0`. Hold overrides both stall and flush.
- Any stage whose rd equals ZERO_REG still propagates its reg_write bit; writeback to x0 is suppressed in the register file, not here.

## Timing
- Reset: every stage register is cleared to a bubble. All `ex_*`, `mem_*`, `wb_*` outputs are 0 the cycle after `rst` is sampled high.
- `pc_write`/`if_id_write` reset to 1; `if_id_flush` resets to 0 (combinational, gated by rst).
- Latency: ID inputs appear on `ex_*` 1 cycle later, `mem_*` 2 cycles later, `wb_*` 3 cycles later, absent hold/stall.
- `stall`, `pc_write`, `if_id_write`, `if_id_flush` are combinational from registered EX state and current ID inputs, valid within the same cycle.
- Reset mid-operation: in-flight instructions are discarded at the same edge; no partial stage survives.
- Back-to-back loads whose consumers each depend on them: one bubble each, never two consecutive.

## Configuration
- `CTRL_PIPE_PERF_CNT_EN`
  - Defined: adds outputs `stall_cnt` out 32 and `flush_cnt` out 32.
  - These count cycles with a stall asserted and cycles with `if_id_flush` asserted.
  - Both clear on `rst`, are frozen during `hold`, and wrap modulo 2^32.
  - Undefined: ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `ctrl_pkg`:
  - RISC-V opcode constants (ALU_R, ALU_I, BRANCH_EQ, JUMP, LOAD, STORE).
  - ALUOp constants (ADD/SUB/R_TYPE).
  - Packed bundle types `id_ex_ctrl_t`, `ex_mem_ctrl_t`, `mem_wb_ctrl_t`.
  - Constant `BUBBLE_CTRL`.
- Sub-module `load_use_detect`: combinational; inputs EX mem_read/rd and ID rs1/rs2; output `stall`.

## Test plan
- Reset with `rst=1` for 2 cycles, then decoder drives R-type (reg_write=1, alu_op=10, rd=5) -> ex_alu_op=10 at +1, mem_reg_write=1 at +2, wb_reg_write=1 and wb_rd=5 at +3.
- LOAD rd=3, then `add` with rs1=3 -> `pc_write=if_id_write=0` for exactly 1 cycle; the bubble reaches EX with all-zero control, and the add appears in EX one cycle later.
- LOAD rd=0, then consumer rs2=0 -> no stall; pc_write stays 1.
- Branch with `id_flush=1` while no hazard -> if_id_flush=1 for that cycle only; same with a concurrent load-use hazard -> if_id_flush=0, stall=1, flush honored next cycle.
- `hold=1` for 3 cycles mid-stream -> all ex/mem/wb outputs constant, pc_write=0; release resumes with no lost or duplicated instruction.
- With `CTRL_PIPE_PERF_CNT_EN`: 2 load-use stalls and 1 flush -> stall_cnt=2, flush_cnt=1; `rst` -> both 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-path types and constants for the ID/EX/MEM/WB control pipeline.
// Used by ctrl_pipeline and load_use_detect.
package ctrl_pkg;

    localparam logic [6:0] OPC_ALU_R     = 7'b0110011;
    localparam logic [6:0] OPC_ALU_I     = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] OPC_JUMP      = 7'b1101111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_SUB    = 2'b01,
        ALUOP_R_TYPE = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_2_reg;
        logic       mem_write;
        logic       reg_write;
        logic       jump;
        logic [4:0] rd;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       mem_2_reg;
        logic       reg_write;
        logic [4:0] rd;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_2_reg;
        logic [4:0] rd;
    } mem_wb_ctrl_t;

    localparam id_ex_ctrl_t  BUBBLE_CTRL        = '0;
    localparam ex_mem_ctrl_t BUBBLE_EX_MEM_CTRL = '0;
    localparam mem_wb_ctrl_t BUBBLE_MEM_WB_CTRL = '0;

    function automatic ex_mem_ctrl_t to_ex_mem(input id_ex_ctrl_t c);
        ex_mem_ctrl_t r;
        r.mem_read  = c.mem_read;
        r.mem_write = c.mem_write;
        r.mem_2_reg = c.mem_2_reg;
        r.reg_write = c.reg_write;
        r.rd        = c.rd;
        return r;
    endfunction

    function automatic mem_wb_ctrl_t to_mem_wb(input ex_mem_ctrl_t c);
        mem_wb_ctrl_t r;
        r.reg_write = c.reg_write;
        r.mem_2_reg = c.mem_2_reg;
        r.rd        = c.rd;
        return r;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently in EX.
module load_use_detect
    import ctrl_pkg::*;
#(
    parameter logic [4:0] ZERO_REG = 5'd0
) (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       stall_o
);

    logic rs_match;

    assign rs_match = (ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i);
    assign stall_o  = ex_mem_read_i & (ex_rd_i != ZERO_REG) & rs_match;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall, IF/ID flush and hold.
// Optional CTRL_PIPE_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter logic [4:0] ZERO_REG = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [1:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_branch,
    input  logic        id_mem_read,
    input  logic        id_mem_2_reg,
    input  logic        id_mem_write,
    input  logic        id_reg_write,
    input  logic        id_jump,
    input  logic        id_flush,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    output logic [1:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic [4:0]  ex_rd,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        wb_reg_write,
    output logic        wb_mem_2_reg,
    output logic [4:0]  wb_rd,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush
`ifdef CTRL_PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    id_ex_ctrl_t  id_ex_q,  id_ex_d;
    ex_mem_ctrl_t ex_mem_q, ex_mem_d;
    mem_wb_ctrl_t mem_wb_q, mem_wb_d;
    logic         stall;

    load_use_detect #(
        .ZERO_REG (ZERO_REG)
    ) u_load_use_detect (
        .ex_mem_read_i (id_ex_q.mem_read),
        .ex_rd_i       (id_ex_q.rd),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .stall_o       (stall)
    );

    always_comb begin
        id_ex_d           = BUBBLE_CTRL;
        id_ex_d.alu_op    = id_alu_op;
        id_ex_d.alu_src   = id_alu_src;
        id_ex_d.branch    = id_branch;
        id_ex_d.mem_read  = id_mem_read;
        id_ex_d.mem_2_reg = id_mem_2_reg;
        id_ex_d.mem_write = id_mem_write;
        id_ex_d.reg_write = id_reg_write;
        id_ex_d.jump      = id_jump;
        id_ex_d.rd        = id_rd;
        if (stall) begin
            id_ex_d = BUBBLE_CTRL;
        end
        ex_mem_d = to_ex_mem(id_ex_q);
        mem_wb_d = to_mem_wb(ex_mem_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= BUBBLE_CTRL;
            ex_mem_q <= BUBBLE_EX_MEM_CTRL;
            mem_wb_q <= BUBBLE_MEM_WB_CTRL;
        end else if (!hold) begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    // Stall outranks flush: the branch compare may depend on the load still in EX.
    assign pc_write    = rst | (~hold & ~stall);
    assign if_id_write = rst | (~hold & ~stall);
    assign if_id_flush = ~rst & ~hold & ~stall & id_flush;

    assign ex_alu_op     = id_ex_q.alu_op;
    assign ex_alu_src    = id_ex_q.alu_src;
    assign ex_rd         = id_ex_q.rd;
    assign mem_mem_read  = ex_mem_q.mem_read;
    assign mem_mem_write = ex_mem_q.mem_write;
    assign mem_rd        = ex_mem_q.rd;
    assign mem_reg_write = ex_mem_q.reg_write;
    assign wb_reg_write  = mem_wb_q.reg_write;
    assign wb_mem_2_reg  = mem_wb_q.mem_2_reg;
    assign wb_rd         = mem_wb_q.rd;

    // branch/jump ride in ID/EX for visibility but are resolved in ID.
    logic unused_id_ex_bits;
    assign unused_id_ex_bits = id_ex_q.branch ^ id_ex_q.jump;

`ifdef CTRL_PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        flush_cnt_d = flush_cnt_q + {31'd0, if_id_flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!hold) begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: directed test-plan sequences plus random
// instruction streams checked against a stage-slot reference model.
module tb_ctrl_pipeline;

    typedef struct {
        logic [1:0] alu_op;
        logic       alu_src, branch, mem_read, mem_2_reg, mem_write, reg_write, jump, flush;
        logic [4:0] rs1, rs2, rd;
    } ins_t;

    typedef struct {
        logic [1:0]  ex_alu_op;
        logic        ex_alu_src;
        logic [4:0]  ex_rd;
        logic        mem_mem_read, mem_mem_write, mem_reg_write;
        logic [4:0]  mem_rd;
        logic        wb_reg_write, wb_mem_2_reg;
        logic [4:0]  wb_rd;
        logic        pc_write, if_id_write, if_id_flush;
        logic [31:0] scnt, fcnt;
    } exp_t;

    logic        clk, rst, hold;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_branch, id_mem_read, id_mem_2_reg, id_mem_write;
    logic        id_reg_write, id_jump, id_flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  ex_alu_op;
    logic        ex_alu_src;
    logic [4:0]  ex_rd;
    logic        mem_mem_read, mem_mem_write, mem_reg_write;
    logic [4:0]  mem_rd;
    logic        wb_reg_write, wb_mem_2_reg;
    logic [4:0]  wb_rd;
    logic        pc_write, if_id_write, if_id_flush;
`ifdef CTRL_PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    ctrl_pipeline dut (
        .clk           (clk),
        .rst           (rst),
        .hold          (hold),
        .id_alu_op     (id_alu_op),
        .id_alu_src    (id_alu_src),
        .id_branch     (id_branch),
        .id_mem_read   (id_mem_read),
        .id_mem_2_reg  (id_mem_2_reg),
        .id_mem_write  (id_mem_write),
        .id_reg_write  (id_reg_write),
        .id_jump       (id_jump),
        .id_flush      (id_flush),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_rd         (ex_rd),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_2_reg  (wb_mem_2_reg),
        .wb_rd         (wb_rd),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush)
`ifdef CTRL_PIPE_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    // Reference model: the instruction occupying each downstream stage.
    ins_t        m_ex, m_mem, m_wb;
    logic [31:0] m_scnt, m_fcnt;
    bit          m_known     = 0;
    bit          last_accept = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t n;
        n.alu_op = 2'b00; n.alu_src = 0; n.branch = 0; n.mem_read = 0; n.mem_2_reg = 0;
        n.mem_write = 0; n.reg_write = 0; n.jump = 0; n.flush = 0;
        n.rs1 = 0; n.rs2 = 0; n.rd = 0;
        return n;
    endfunction

    function automatic ins_t mk_load(input logic [4:0] rd, input logic [4:0] rs1);
        ins_t n = nop();
        n.mem_read = 1; n.mem_2_reg = 1; n.reg_write = 1; n.alu_src = 1;
        n.rd = rd; n.rs1 = rs1;
        return n;
    endfunction

    function automatic ins_t mk_rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ins_t n = nop();
        n.reg_write = 1; n.alu_op = 2'b10; n.rd = rd; n.rs1 = rs1; n.rs2 = rs2;
        return n;
    endfunction

    function automatic ins_t mk_branch(input logic [4:0] rs1, input logic [4:0] rs2, input logic tk);
        ins_t n = nop();
        n.branch = 1; n.alu_op = 2'b01; n.flush = tk; n.rs1 = rs1; n.rs2 = rs2;
        return n;
    endfunction

    function automatic ins_t rand_ins();
        ins_t n;
        case ($urandom_range(0, 4))
            0: n = mk_load(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            1: n = mk_rtype(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            2: begin
                n = nop(); n.mem_write = 1; n.alu_src = 1;
                n.rs1 = 5'($urandom_range(0, 3)); n.rs2 = 5'($urandom_range(0, 3));
            end
            3: n = mk_branch(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            default: begin
                n.alu_op = 2'($urandom); n.alu_src = 1'($urandom); n.branch = 1'($urandom);
                n.mem_read = 1'($urandom); n.mem_2_reg = 1'($urandom); n.mem_write = 1'($urandom);
                n.reg_write = 1'($urandom); n.jump = 1'($urandom); n.flush = 1'($urandom);
                n.rs1 = 5'($urandom); n.rs2 = 5'($urandom); n.rd = 5'($urandom);
            end
        endcase
        return n;
    endfunction

    // Drive one cycle of ID inputs, record what the DUT must show this cycle,
    // then advance the model across the coming edge.
    task automatic drive(input ins_t in, input logic h, input logic r);
        exp_t e;
        bit   hz;
        id_alu_op = in.alu_op; id_alu_src = in.alu_src; id_branch = in.branch;
        id_mem_read = in.mem_read; id_mem_2_reg = in.mem_2_reg; id_mem_write = in.mem_write;
        id_reg_write = in.reg_write; id_jump = in.jump; id_flush = in.flush;
        id_rs1 = in.rs1; id_rs2 = in.rs2; id_rd = in.rd;
        hold = h; rst = r;

        hz = m_ex.mem_read && (m_ex.rd != 5'd0) && (m_ex.rd == in.rs1 || m_ex.rd == in.rs2);
        e.ex_alu_op     = m_ex.alu_op;
        e.ex_alu_src    = m_ex.alu_src;
        e.ex_rd         = m_ex.rd;
        e.mem_mem_read  = m_mem.mem_read;
        e.mem_mem_write = m_mem.mem_write;
        e.mem_reg_write = m_mem.reg_write;
        e.mem_rd        = m_mem.rd;
        e.wb_reg_write  = m_wb.reg_write;
        e.wb_mem_2_reg  = m_wb.mem_2_reg;
        e.wb_rd         = m_wb.rd;
        e.pc_write      = r || (!h && !hz);
        e.if_id_write   = e.pc_write;
        e.if_id_flush   = !r && !h && !hz && in.flush;
        e.scnt          = m_scnt;
        e.fcnt          = m_fcnt;
        if (m_known) sb_q.push_back(e);

        last_accept = r || (!h && !hz);
        if (r) begin
            m_ex = nop(); m_mem = nop(); m_wb = nop();
            m_scnt = 0; m_fcnt = 0; m_known = 1;
        end else if (!h) begin
            if (hz) m_scnt = m_scnt + 1;
            if (e.if_id_flush) m_fcnt = m_fcnt + 1;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = hz ? nop() : in;
        end
        @(posedge clk);
        #1;
    endtask

    // Present an instruction until the pipeline accepts it (a stall retries it).
    task automatic issue(input ins_t in);
        int g = 0;
        do begin
            drive(in, 1'b0, 1'b0);
            g++;
        end while (!last_accept && g < 4);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("ex_alu_op",     {30'd0, ex_alu_op},    {30'd0, e.ex_alu_op});
            chk("ex_alu_src",    {31'd0, ex_alu_src},   {31'd0, e.ex_alu_src});
            chk("ex_rd",         {27'd0, ex_rd},        {27'd0, e.ex_rd});
            chk("mem_mem_read",  {31'd0, mem_mem_read}, {31'd0, e.mem_mem_read});
            chk("mem_mem_write", {31'd0, mem_mem_write},{31'd0, e.mem_mem_write});
            chk("mem_reg_write", {31'd0, mem_reg_write},{31'd0, e.mem_reg_write});
            chk("mem_rd",        {27'd0, mem_rd},       {27'd0, e.mem_rd});
            chk("wb_reg_write",  {31'd0, wb_reg_write}, {31'd0, e.wb_reg_write});
            chk("wb_mem_2_reg",  {31'd0, wb_mem_2_reg}, {31'd0, e.wb_mem_2_reg});
            chk("wb_rd",         {27'd0, wb_rd},        {27'd0, e.wb_rd});
            chk("pc_write",      {31'd0, pc_write},     {31'd0, e.pc_write});
            chk("if_id_write",   {31'd0, if_id_write},  {31'd0, e.if_id_write});
            chk("if_id_flush",   {31'd0, if_id_flush},  {31'd0, e.if_id_flush});
`ifdef CTRL_PIPE_PERF_CNT_EN
            chk("stall_cnt", stall_cnt, e.scnt);
            chk("flush_cnt", flush_cnt, e.fcnt);
`endif
        end
    end

    initial begin
        ins_t cur;
        m_ex = nop(); m_mem = nop(); m_wb = nop();
        m_scnt = 0; m_fcnt = 0;
        rst = 1; hold = 0;
        id_alu_op = 0; id_alu_src = 0; id_branch = 0; id_mem_read = 0; id_mem_2_reg = 0;
        id_mem_write = 0; id_reg_write = 0; id_jump = 0; id_flush = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;

        drive(nop(), 1'b0, 1'b1);
        drive(nop(), 1'b0, 1'b1);

        // R-type latency through EX/MEM/WB
        issue(mk_rtype(5'd5, 5'd1, 5'd2));
        repeat (4) issue(nop());

        // load-use on rs1 stalls once, then the add proceeds
        issue(mk_load(5'd3, 5'd1));
        issue(mk_rtype(5'd6, 5'd3, 5'd4));
        repeat (3) issue(nop());

        // load to the zero register never stalls
        issue(mk_load(5'd0, 5'd1));
        issue(mk_rtype(5'd7, 5'd2, 5'd0));
        repeat (3) issue(nop());

        // taken branch without hazard, then with a concurrent load-use hazard
        issue(mk_branch(5'd1, 5'd2, 1'b1));
        issue(nop());
        issue(mk_load(5'd7, 5'd2));
        issue(mk_branch(5'd7, 5'd1, 1'b1));
        repeat (3) issue(nop());

        // back-to-back dependent loads
        issue(mk_load(5'd1, 5'd2));
        issue(mk_load(5'd2, 5'd1));
        issue(mk_rtype(5'd3, 5'd2, 5'd2));
        repeat (3) issue(nop());

        // 3-cycle hold mid-stream
        issue(mk_rtype(5'd9, 5'd1, 5'd2));
        issue(mk_load(5'd10, 5'd3));
        repeat (3) drive(mk_rtype(5'd11, 5'd10, 5'd1), 1'b1, 1'b0);
        issue(mk_rtype(5'd11, 5'd10, 5'd1));
        repeat (4) issue(nop());

        // reset mid-operation
        issue(mk_load(5'd4, 5'd1));
        issue(mk_rtype(5'd5, 5'd1, 5'd2));
        drive(mk_rtype(5'd6, 5'd4, 5'd1), 1'b0, 1'b1);
        repeat (3) issue(nop());

        cur = rand_ins();
        for (int i = 0; i < 3000; i++) begin
            if (last_accept) cur = rand_ins();
            drive(cur, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) == 0));
        end

`ifdef CTRL_PIPE_PERF_CNT_EN
        drive(nop(), 1'b0, 1'b1);
        drive(nop(), 1'b0, 1'b1);
        issue(mk_load(5'd3, 5'd1));
        issue(mk_rtype(5'd6, 5'd3, 5'd4));
        issue(mk_load(5'd4, 5'd1));
        issue(mk_rtype(5'd7, 5'd1, 5'd4));
        issue(mk_branch(5'd1, 5'd2, 1'b1));
        repeat (2) issue(nop());
        chk("stall_cnt_total", stall_cnt, 32'd2);
        chk("flush_cnt_total", flush_cnt, 32'd1);
        drive(nop(), 1'b0, 1'b1);
        chk("stall_cnt_rst", stall_cnt, 32'd0);
        chk("flush_cnt_rst", flush_cnt, 32'd0);
`endif

        drive(nop(), 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
